// File: rtl/multi_switch_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// multi_switch_ctrl
//
// Purpose: N-channel push-button light controller. Each channel debounces its
// raw button level, emits a one-cycle strobe per accepted press (debounced
// rising edge), and drives its light output in one of three global modes:
// toggle, momentary, or timed auto-off.
//
// Ports:
//   clk      in   system clock, rising-edge active
//   rst_n    in   asynchronous active-low reset
//   btn      in   [N_CH] raw button levels, 1 = pressed
//   mode     in   [2] 00 toggle, 01 momentary, 10 timed, 11 reserved (toggle)
//   all_off  in   synchronous clear of all lights and timers
//   light    out  [N_CH] light state per channel, 1 = on
//   press    out  [N_CH] one-cycle strobe per accepted press
//
// Optional build macro: MULTI_SWITCH_SYNC_EN
//   Defined     -> btn passes through a 2-flop synchroniser (adds 2 cycles).
//   Not defined -> btn drives the debouncer directly (must be clk-synchronous).
// -----------------------------------------------------------------------------
module multi_switch_ctrl #(
  parameter int N_CH       = 4,
  parameter int DEB_CYCLES = 4,
  parameter int TIMEOUT    = 1000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] btn,
  input  logic [1:0]      mode,
  input  logic            all_off,
  output logic [N_CH-1:0] light,
  output logic [N_CH-1:0] press
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  // Counter value on which the next mismatching cycle would reach DEB_CYCLES.
  localparam logic [CW-1:0] DEB_LAST   = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

  typedef enum logic [1:0] {
    MODE_TOGGLE    = 2'b00,
    MODE_MOMENTARY = 2'b01,
    MODE_TIMED     = 2'b10,
    MODE_RSVD      = 2'b11
  } mode_e;

  logic [N_CH-1:0] btn_s;
  mode_e           mode_q;
  logic            mode_chg;
  logic            clear_all;

`ifdef MULTI_SWITCH_SYNC_EN
  logic [N_CH-1:0] sync1_q;
  logic [N_CH-1:0] sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
    end
  end

  assign btn_s = sync2_q;
`else
  assign btn_s = btn;
`endif

  // Mode is sampled every cycle; a mismatch between the live input and the
  // registered copy clears every light/timer on that edge and the new mode
  // takes over from the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_TOGGLE;
    end else begin
      mode_q <= mode_e'(mode);
    end
  end

  assign mode_chg  = (mode != mode_q);
  assign clear_all = all_off | mode_chg;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [CW-1:0] cnt_q, cnt_d;
      logic          stable_q, stable_d;
      logic          press_q, press_d;
      logic          light_q, light_d;
      logic [TW-1:0] timer_q, timer_d;

      // Debouncer: count consecutive cycles the raw level disagrees with the
      // accepted level; accept it on the cycle the count would hit DEB_CYCLES.
      always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        if (btn_s[gi] != stable_q) begin
          if (cnt_q == DEB_LAST) begin
            stable_d = btn_s[gi];
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        // Strobe registers together with the accepted level, so it is high
        // in exactly the cycle stable first reads 1.
        press_d = stable_d & ~stable_q;
      end

      // Light/timer update works from the registered strobe and level, so the
      // light follows one cycle after the debouncer.
      always_comb begin
        light_d = light_q;
        timer_d = timer_q;
        if (clear_all) begin
          light_d = 1'b0;
          timer_d = '0;
        end else begin
          case (mode_q)
            MODE_MOMENTARY: begin
              light_d = stable_q;
              timer_d = '0;
            end
            MODE_TIMED: begin
              if (press_q) begin
                light_d = 1'b1;
                timer_d = TIMER_LOAD;
              end else if (light_q) begin
                // Expire on the 1->0 step; a zero timer with the light on
                // cannot stay on either.
                if (timer_q <= TIMER_ONE) begin
                  light_d = 1'b0;
                  timer_d = '0;
                end else begin
                  timer_d = timer_q - TIMER_ONE;
                end
              end
            end
            default: begin
              light_d = light_q ^ press_q;
              timer_d = '0;
            end
          endcase
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q    <= '0;
          stable_q <= 1'b0;
          press_q  <= 1'b0;
          light_q  <= 1'b0;
          timer_q  <= '0;
        end else begin
          cnt_q    <= cnt_d;
          stable_q <= stable_d;
          press_q  <= press_d;
          light_q  <= light_d;
          timer_q  <= timer_d;
        end
      end

      assign light[gi] = light_q;
      assign press[gi] = press_q;
    end
  endgenerate

endmodule
